// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the pattern scan controller: FSM encoding,
// cross-scan mask depth and detector flag positions.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // The detector only has a full three-bit window from scan index 2 on.
    localparam int SCAN_MASK = 2;

    localparam int DET_101 = 1;
    localparam int DET_010 = 0;

endpackage

// File: rtl/pattern_scan_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at its maximum
// instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pattern_scan_controller.sv
// Serialises a parallel word MSB-first into an external 101/010 detector and
// counts its flags. Define PATTERN_SCAN_HITMAP_EN to build the hit_map register.
module pattern_scan_controller
    import pattern_scan_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             bit_out,
    input  logic [1:0]       det_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_101,
    output logic [CNT_W-1:0] cnt_010,
    output logic [WIDTH-1:0] hit_map
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LIVE_IDX = IDX_W'(SCAN_MASK);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             clr;
    logic             inc_101;
    logic             inc_010;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        clr     = 1'b0;
        inc_101 = 1'b0;
        inc_010 = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = data_in;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            S_SHIFT: begin
                shift_d = shift_q << 1;
                // Flags at the first indices reflect history from the previous scan.
                if (idx_q >= LIVE_IDX) begin
                    inc_101 = det_in[DET_101];
                    inc_010 = det_in[DET_010];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_SHIFT);
    assign done    = (state_q == S_DONE);
    assign bit_out = busy & shift_q[WIDTH-1];

    sat_counter #(.CNT_W(CNT_W)) u_cnt_101 (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (inc_101),
        .q       (cnt_101)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_010 (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (inc_010),
        .q       (cnt_010)
    );

`ifdef PATTERN_SCAN_HITMAP_EN
    logic [WIDTH-1:0] hit_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= '0;
        end else if (clr) begin
            hit_q <= '0;
        end else if (inc_101) begin
            hit_q[idx_q] <= 1'b1;
        end
    end

    assign hit_map = hit_q;
`else
    assign hit_map = '0;
`endif

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Scoreboard bench for pattern_scan_controller with a behavioural 101/010
// detector attached to bit_out/det_in.
module tb_pattern_scan_controller;

    localparam int W  = 9;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  data_in;
    logic          bit_out;
    logic [1:0]    det_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt_101;
    logic [CW-1:0] cnt_010;
    logic [W-1:0]  hit_map;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        string         name;
        logic [CW-1:0] c101;
        logic [CW-1:0] c010;
        logic [W-1:0]  hit;
        int            doneCyc;
    } exp_t;

    exp_t sbq[$];

    pattern_scan_controller #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_in),
        .bit_out (bit_out),
        .det_in  (det_in),
        .busy    (busy),
        .done    (done),
        .cnt_101 (cnt_101),
        .cnt_010 (cnt_010),
        .hit_map (hit_map)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // External Mealy detector: remembers the last two serial bits forever.
    logic [1:0] detHist;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) detHist <= 2'b00;
        else          detHist <= {detHist[0], bit_out};
    end
    assign det_in = {(detHist == 2'b10) && bit_out, (detHist == 2'b01) && !bit_out};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count patterns fully inside the word, then saturate.
    function automatic void refScan(input logic [W-1:0] w, output logic [CW-1:0] c101,
                                    output logic [CW-1:0] c010, output logic [W-1:0] hit);
        int n101 = 0;
        int n010 = 0;
        int maxc = (1 << CW) - 1;
        bit b[W];
        hit = '0;
        for (int k = 0; k < W; k++) b[k] = w[W-1-k];
        for (int k = 2; k < W; k++) begin
            if (b[k-2] && !b[k-1] && b[k]) begin
                n101++;
                hit[k] = 1'b1;
            end
            if (!b[k-2] && b[k-1] && !b[k]) n010++;
        end
        c101 = CW'((n101 > maxc) ? maxc : n101);
        c010 = CW'((n010 > maxc) ? maxc : n010);
    endfunction

    // Called at a negedge with the DUT idle or done; returns at the negedge of the DONE cycle.
    task automatic applyStimulus(input string name, input logic [W-1:0] w,
                                 input logic [CW-1:0] e101, input logic [CW-1:0] e010,
                                 input logic [W-1:0] ehit, input bit hold, input int abortAt);
        exp_t e;
        e.name    = name;
        e.c101    = e101;
        e.c010    = e010;
`ifdef PATTERN_SCAN_HITMAP_EN
        e.hit     = ehit;
`else
        e.hit     = '0;
`endif
        e.doneCyc = cyc + 1 + W;
        sbq.push_back(e);
        start   = 1'b1;
        data_in = w;
        @(posedge clock);
        for (int k = 0; k < W; k++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            data_in = W'($urandom);
            checkOutput($sformatf("%s busy/bit%0d", name, k), {30'd0, busy, bit_out}, {30'd0, 1'b1, w[W-1-k]});
            if (k == abortAt) begin
                start   = 1'b0;
                reset_n = 1'b0;
                void'(sbq.pop_back());
                #1;
                checkOutput($sformatf("%s reset busy/done/bit", name), {29'd0, busy, done, bit_out}, 32'd0);
                checkOutput($sformatf("%s reset counts", name), {28'd0, cnt_101, cnt_010}, 32'd0);
                checkOutput($sformatf("%s reset hit_map", name), {23'd0, hit_map}, 32'd0);
                @(negedge clock);
                #2 reset_n = 1'b1;
                @(negedge clock);
                return;
            end
        end
        @(negedge clock);
        if (!hold) start = 1'b0;
    endtask

    logic prevDone = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (done && !prevDone) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput({e.name, " cnt_101"}, {30'd0, cnt_101}, {30'd0, e.c101});
                checkOutput({e.name, " cnt_010"}, {30'd0, cnt_010}, {30'd0, e.c010});
                checkOutput({e.name, " hit_map"}, {23'd0, hit_map}, {23'd0, e.hit});
                checkOutput({e.name, " done cycle"}, cyc, e.doneCyc);
                checkOutput({e.name, " busy in done"}, {31'd0, busy}, 32'd0);
            end
        end
        prevDone = done;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        tests++;
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [W-1:0]  w;
        logic [CW-1:0] r101, r010;
        logic [W-1:0]  rhit;

        reset_n = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset busy/done/bit", {29'd0, busy, done, bit_out}, 32'd0);
        checkOutput("reset counts", {28'd0, cnt_101, cnt_010}, 32'd0);
        checkOutput("reset hit_map", {23'd0, hit_map}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        applyStimulus("basic", 9'b101001101, 2'd2, 2'd1, 9'b100000100, 1'b0, -1);
        @(negedge clock);
        applyStimulus("saturate", 9'b101010101, 2'd3, 2'd3, 9'b101010100, 1'b0, -1);
        applyStimulus("crossA", 9'b000000010, 2'd0, 2'd1, 9'b000000000, 1'b0, -1);
        applyStimulus("crossB", 9'b100000000, 2'd0, 2'd0, 9'b000000000, 1'b0, -1);
        applyStimulus("heldA", 9'b110110110, 2'd2, 2'd0, 9'b001001000, 1'b1, -1);
        applyStimulus("heldB", 9'b110110110, 2'd2, 2'd0, 9'b001001000, 1'b0, -1);
        applyStimulus("abort", 9'b111111111, 2'd0, 2'd0, 9'b0, 1'b0, 4);
        applyStimulus("postAbort", 9'b101001101, 2'd2, 2'd1, 9'b100000100, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            w = W'($urandom);
            refScan(w, r101, r010, rhit);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            applyStimulus($sformatf("rand%0d", n), w, r101, r010, rhit, 1'b0, -1);
        end

        repeat (3) @(negedge clock);
        checkOutput("scoreboard drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_scan_controller.md
# pattern_scan_controller

Sequencer that feeds a parallel word, one bit per cycle, MSB first, into the external 3-bit Mealy pattern detector (outputs "101" and "010" flags). It collects the detector's flags into per-pattern saturating counts and reports completion with a busy/done handshake. It sits between a parallel producer (bench or host register) and the serial detector. It also masks detections that straddle two scans, because the detector's history registers carry over between scans.

## Interface
Parameters:
- WIDTH, 9: bits per scanned word; minimum 3.
- CNT_W, 4: width of each match counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan of data_in. Sampled only in IDLE or DONE.
- data_in  in  WIDTH  word to scan. Captured on the accepting edge.
- bit_out  out  1  serial bit to the detector's i input.
- det_in  in  2  detector output o; [1] = "101" ends now, [0] = "010" ends now. Combinational with respect to bit_out.
- busy  out  1  high while in SHIFT.
- done  out  1  high in DONE. Held until the next accepted start.
- cnt_101  out  CNT_W  "101" matches in the last scan.
- cnt_010  out  CNT_W  "010" matches in the last scan.
- hit_map  out  WIDTH  bit k set if "101" ended at scan index k. Only present with the macro; see Configuration.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
  - Reset state is IDLE.
  - IDLE or DONE, with start=1: go to SHIFT. On the same edge, load the shift register with data_in, set idx=0, clear both counters and hit_map, and clear done.
  - SHIFT, with idx < WIDTH-1: stay in SHIFT and increment idx.
  - SHIFT, with idx = WIDTH-1: go to DONE.
  - start is ignored while in SHIFT. The scan is not restarted and no request is queued.
- bit_out equals the MSB of the shift register in SHIFT and 0 otherwise. The shift register shifts left by one on each SHIFT edge.
- Each SHIFT edge samples det_in for the current idx:
  - If idx >= 2 and det_in[1]=1: increment cnt_101 and set hit_map[idx].
  - If idx >= 2 and det_in[0]=1: increment cnt_010.
  - At idx 0 and 1, det_in is discarded. This is the cross-scan mask.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Counts and hit_map are stable in DONE and IDLE. They are cleared only by the next accepted start or by reset.

## Timing
- Reset values: state IDLE, bit_out 0, busy 0, done 0, cnt_101 0, cnt_010 0, hit_map 0, idx 0, shift register 0.
- Accept happens at edge A, where start=1 is sampled.
  - busy rises after A.
  - bit_out carries data_in[WIDTH-1] during cycle A+1, data_in[WIDTH-2] during A+2, and so on.
- det_in for index k is sampled at edge A+1+k.
- At edge A+WIDTH the FSM enters DONE: busy falls, done rises, and final counts are visible in the same cycle.
- Total latency from the accept edge to done is WIDTH cycles.
- Back-to-back scans: start=1 while in DONE is accepted on that edge. done drops and busy rises in the same cycle, with no idle gap.
- reset_n low at any time, including mid-scan: asynchronously forces all reset values, and no partial counts survive. Operation resumes on the first edge after reset_n goes high.

## Configuration
- PATTERN_SCAN_HITMAP_EN defined: the hit_map port and its register exist, and behave as described above.
- PATTERN_SCAN_HITMAP_EN undefined: the hit_map port still exists but is tied to 0, and no register is synthesized.
- Counts and handshake behave identically in both cases.

## Structure
- Shared package pattern_scan_pkg holds:
  - the FSM state encoding: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - the mask-depth constant SCAN_MASK=2;
  - the detector flag indices DET_101=1 and DET_010=0.
- One sub-module, sat_counter:
  - parameter CNT_W;
  - ports: clock, reset_n, clr, inc, q;
  - saturates at its maximum value;
  - instantiated twice, once for cnt_101 and once for cnt_010.
- The detector itself stays external. The bench connects bit_out to its i input and its o output to det_in.

## Test plan
- Reset mid-scan: reset_n pulsed low during SHIFT at idx=4 -> busy=0, done=0, counts 0, and bit_out=0 immediately. The next start performs a full scan.
- Basic scan: WIDTH=9, data_in=9'b101001101 -> done 9 cycles after accept, cnt_101=2, cnt_010=1, hit_map=9'b100000100 (with the macro) or 0 (without).
- Saturation: CNT_W=2, data_in=9'b101010101 -> cnt_101=3 (4 raw matches, saturated), cnt_010=3.
- Cross-scan mask: scan 9'b000000010, then immediately scan 9'b100000000 from DONE -> first scan gives cnt_010=1, cnt_101=0; second scan gives cnt_101=0, cnt_010=0, so no false "101" from carried history.
- Start during busy: start held high throughout a scan of 9'b110110110 -> exactly one scan completes, then a second scan is accepted in DONE with no gap. Each scan gives cnt_101=2, cnt_010=0.
